register_file_scanner: RTL

Read-side sequencer for the 18-bit, 16-entry register file. On a start command it walks an inclusive register range, driving both read ports two registers at a time, absorbing the file's one-cycle registered read latency, and streams each 18-bit value out over a valid/ready interface. It sits between the register file's read ports and a debug/dump consumer, such as a UART transmitter or trace buffer.

---
 rtl/register_file_scanner.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/register_file_scanner.sv
// Read-side sequencer that walks a register range two entries per fetch and streams
// each 18-bit value over valid/ready. Define SCAN_INDEX_EN to add the out_index port.
module register_file_scanner (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  first_reg,
  input  logic [3:0]  last_reg,
  output logic [3:0]  rf_read1,
  output logic [3:0]  rf_read2,
  output logic        rf_enable,
  input  logic [17:0] rf_data1,
  input  logic [17:0] rf_data2,
  output logic [17:0] out_data,
`ifdef SCAN_INDEX_EN
  output logic [3:0]  out_index,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, EMIT_A, EMIT_B, DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  ptr, ptr_nx, ptr2, diff;
  logic [4:0]  rem, rem_nx, rem2, span;
  logic [17:0] word_b, word_b_nx;
  logic [3:0]  rd1_nx, rd2_nx;
  logic [17:0] data_nx;
  logic        en_nx, valid_nx, busy_nx, done_nx;
`ifdef SCAN_INDEX_EN
  logic [3:0]  idx_nx;
`endif

  assign diff = last_reg - first_reg;
  assign span = {1'b0, diff} + 5'd1;
  assign ptr2 = ptr + 4'd2;
  assign rem2 = rem - 5'd2;

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    rem_nx    = rem;
    word_b_nx = word_b;
    rd1_nx    = rf_read1;
    rd2_nx    = rf_read2;
    en_nx     = 1'b0;
    data_nx   = out_data;
    valid_nx  = out_valid;
    busy_nx   = busy;
    done_nx   = 1'b0;
`ifdef SCAN_INDEX_EN
    idx_nx    = out_index;
`endif
    case (state)
      IDLE: if (start) begin
        state_nx = FETCH;
        ptr_nx   = first_reg;
        rem_nx   = span;
        busy_nx  = 1'b1;
        en_nx    = 1'b1;
        rd1_nx   = first_reg;
        // a lone last word reads the same register on both ports to stay in range
        rd2_nx   = (span == 5'd1) ? first_reg : first_reg + 4'd1;
      end
      FETCH:   state_nx = CAPTURE;
      CAPTURE: begin
        state_nx  = EMIT_A;
        valid_nx  = 1'b1;
        data_nx   = rf_data1;
        word_b_nx = rf_data2;
`ifdef SCAN_INDEX_EN
        idx_nx    = ptr;
`endif
      end
      EMIT_A: if (out_ready) begin
        if (rem == 5'd1) begin
          state_nx = DONE;
          valid_nx = 1'b0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          state_nx = EMIT_B;
          data_nx  = word_b;
`ifdef SCAN_INDEX_EN
          idx_nx   = ptr + 4'd1;
`endif
        end
      end
      EMIT_B: if (out_ready) begin
        ptr_nx   = ptr2;
        rem_nx   = rem2;
        valid_nx = 1'b0;
        if (rem2 == 5'd0) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          state_nx = FETCH;
          en_nx    = 1'b1;
          rd1_nx   = ptr2;
          rd2_nx   = (rem2 == 5'd1) ? ptr2 : ptr2 + 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
      en_nx    = 1'b0;
      valid_nx = 1'b0;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= 4'd0;
      rem       <= 5'd0;
      word_b    <= 18'd0;
      rf_read1  <= 4'd0;
      rf_read2  <= 4'd0;
      rf_enable <= 1'b0;
      out_data  <= 18'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SCAN_INDEX_EN
      out_index <= 4'd0;
`endif
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      rem       <= rem_nx;
      word_b    <= word_b_nx;
      rf_read1  <= rd1_nx;
      rf_read2  <= rd2_nx;
      rf_enable <= en_nx;
      out_data  <= data_nx;
      out_valid <= valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
`ifdef SCAN_INDEX_EN
      out_index <= idx_nx;
`endif
    end
  end

endmodule
